aes_key_schedule_ctrl: RTL

Sequential AES-128 key-schedule controller.
- Accepts a 128-bit cipher key through a valid/ready handshake.
- Iterates one round-key expansion step per round, tracking the round counter and Rcon internally.
- Stores all 11 round keys in an internal buffer.
- Sits between the key-load interface and the round engine, which reads round keys by index through a random-access read port.

---
 rtl/aes_key_schedule_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller: 11-slot round-key buffer, one step per round.
// KS_SERIAL_SBOX_EN selects a single shared S-box (4 sub-cycles per step).
module aes_key_schedule_ctrl #(
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         keys_valid
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } st_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  st_t          st_q, st_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] slot_q [11];
  logic         slot_we;
  logic [3:0]   slot_wa;
  logic [127:0] slot_wd;

  logic [127:0] cur;
  logic [31:0]  w0, w1, w2, w3, rw, t;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic         step_done;

  assign cur = slot_q[r_q];
  assign w0  = cur[127:96];
  assign w1  = cur[95:64];
  assign w2  = cur[63:32];
  assign w3  = cur[31:0];
  assign rw  = {w3[23:0], w3[31:24]};

`ifdef KS_SERIAL_SBOX_EN
  logic [1:0]  s_q, s_d;
  logic [23:0] tmp_q, tmp_d;
  logic [7:0]  sb_in, sb_out;

  always_comb begin
    sb_in = rw[31:24];
    unique case (s_q)
      2'd0: sb_in = rw[31:24];
      2'd1: sb_in = rw[23:16];
      2'd2: sb_in = rw[15:8];
      2'd3: sb_in = rw[7:0];
    endcase
  end

  assign sb_out    = SBOX[sb_in];
  assign t         = {tmp_q, sb_out};
  assign step_done = (s_q == 2'd3);
`else
  assign t = {SBOX[rw[31:24]], SBOX[rw[23:16]],
              SBOX[rw[15:8]],  SBOX[rw[7:0]]};
  assign step_done = 1'b1;
`endif

  assign nw0 = w0 ^ t ^ {rcon(r_q), 24'h0};
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  always_comb begin
    st_d    = st_q;
    r_d     = r_q;
    slot_we = 1'b0;
    slot_wa = 4'(r_q + 4'd1);
    slot_wd = {nw0, nw1, nw2, nw3};
`ifdef KS_SERIAL_SBOX_EN
    s_d     = s_q;
    tmp_d   = tmp_q;
`endif
    if (abort) begin
      st_d = IDLE;
      r_d  = 4'd0;
`ifdef KS_SERIAL_SBOX_EN
      s_d  = 2'd0;
`endif
    end else begin
      unique case (st_q)
        IDLE, READY: begin
          if (key_valid) begin
            slot_we = 1'b1;
            slot_wa = 4'd0;
            slot_wd = key_in;
            r_d     = 4'd0;
            st_d    = EXPAND;
`ifdef KS_SERIAL_SBOX_EN
            s_d     = 2'd0;
`endif
          end
        end
        EXPAND: begin
          if (step_done) begin
            slot_we = 1'b1;
            r_d     = 4'(r_q + 4'd1);
            if (r_q == 4'd9) st_d = READY;
          end
`ifdef KS_SERIAL_SBOX_EN
          s_d = 2'(s_q + 2'd1);
          if (!step_done) tmp_d = {tmp_q[15:0], sb_out};
`endif
        end
        default: st_d = IDLE;
      endcase
    end
    // reset mid-expansion must not corrupt a slot
    if (!rst_n) slot_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      r_q   <= 4'd0;
`ifdef KS_SERIAL_SBOX_EN
      s_q   <= 2'd0;
      tmp_q <= 24'h0;
`endif
    end else begin
      st_q  <= st_d;
      r_q   <= r_d;
`ifdef KS_SERIAL_SBOX_EN
      s_q   <= s_d;
      tmp_q <= tmp_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (slot_we) slot_q[slot_wa] <= slot_wd;
  end

  assign key_ready  = (st_q != EXPAND);
  assign busy       = (st_q == EXPAND);
  assign keys_valid = (st_q == READY);

  logic [127:0] rd_d;
  assign rd_d = (rk_idx <= 4'd10) ? slot_q[rk_idx] : 128'h0;

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= 128'h0;
        else        rd_q <= rd_d;
      end
      assign rk_out = rd_q;
    end else begin : g_rd_comb
      assign rk_out = rst_n ? rd_d : 128'h0;
    end
  endgenerate

endmodule
